// File: rtl/aurora_hls_tx_arb_pkg.sv
// Shared types and helpers for the Aurora TX stream arbiter.
// Optional feature macro used by the arbiter: AURORA_TX_ARB_PACKET_EN.
package aurora_hls_tx_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    // Picker works on a fixed 8-wide view; narrower requester sets are zero-extended.
    localparam int unsigned MAX_N_REQ = 8;
    localparam int unsigned PICK_W    = 3;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned idx_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping modulo n_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_N_REQ-1:0] valid,
                                         input logic [PICK_W-1:0]    ptr,
                                         input int unsigned          n_req);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned off = 0; off < MAX_N_REQ; off++) begin
            j = (32'(ptr) + off) % n_req;
            if (!r.found && (off < n_req) && valid[j[PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[PICK_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aurora_hls_rr_picker.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, unrotate.
module aurora_hls_rr_picker
    import aurora_hls_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_N_REQ'(valid), PICK_W'(ptr), N_REQ);
    end

    assign found = pick.found;
    assign idx   = IDX_W'(pick.idx);

endmodule

// File: rtl/aurora_hls_tx_arbiter.sv
// Round-robin burst arbiter feeding the Aurora TX FIFO AXI-Stream input.
// Define AURORA_TX_ARB_PACKET_EN for frame-granular (tlast) arbitration with tkeep/tlast.
module aurora_hls_tx_arbiter
    import aurora_hls_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_REQ*DATA_W-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]        s_axis_tvalid,
    output logic [N_REQ-1:0]        s_axis_tready,
`ifdef AURORA_TX_ARB_PACKET_EN
    input  logic [N_REQ-1:0]            s_axis_tlast,
    input  logic [N_REQ*DATA_W/8-1:0]   s_axis_tkeep,
`endif
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
`ifdef AURORA_TX_ARB_PACKET_EN
    output logic                    m_axis_tlast,
    output logic [DATA_W/8-1:0]     m_axis_tkeep,
`endif
    input  logic                    fifo_tx_prog_full,
    output logic [N_REQ-1:0]        grant,
    output logic [31:0]             tx_beats
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
`ifdef AURORA_TX_ARB_PACKET_EN
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned KEEP_W = DATA_W / 8;
`else
    localparam int unsigned CNT_W  = cnt_width(MAX_BURST);
`endif

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]      tx_beats_q, tx_beats_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             accept;
    logic             burst_end;

    aurora_hls_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid (s_axis_tvalid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Pass-through datapath; everything is gated to zero outside a burst.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
`ifdef AURORA_TX_ARB_PACKET_EN
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
`endif
        if (state_q == StBurst) begin
            m_axis_tdata  = s_axis_tdata[32'(gidx_q)*DATA_W +: DATA_W];
            m_axis_tvalid = s_axis_tvalid[gidx_q];
`ifdef AURORA_TX_ARB_PACKET_EN
            m_axis_tlast  = s_axis_tlast[gidx_q];
            m_axis_tkeep  = s_axis_tkeep[32'(gidx_q)*KEEP_W +: KEEP_W];
`endif
        end
    end

    assign s_axis_tready = grant_q & {N_REQ{m_axis_tready}};
    assign accept        = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        tx_beats_d = tx_beats_q + 32'(accept);
        burst_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_tx_prog_full && pick_found) begin
                    state_d    = StBurst;
                    gidx_d     = pick_idx;
                    grant_d    = N_REQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            StBurst: begin
`ifdef AURORA_TX_ARB_PACKET_EN
                if (accept && (beat_cnt_q != {CNT_W{1'b1}})) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Frames are never split: only the closing beat releases the grant.
                burst_end = accept & m_axis_tlast;
`else
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                burst_end = accept ? (beat_cnt_q == CNT_W'(MAX_BURST - 1)) : !m_axis_tvalid;
`endif
                if (burst_end) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    gidx_d   = '0;
                    rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            tx_beats_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            tx_beats_q <= tx_beats_d;
        end
    end

    assign grant    = grant_q;
    assign tx_beats = tx_beats_q;

    grant_onehot_a : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        $onehot0(grant_q));
    grant_matches_state_a : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        ((state_q == StIdle) == (grant_q == '0)));

endmodule

// File: tb/tb_aurora_hls_tx_arbiter.sv
// Randomized bench for aurora_hls_tx_arbiter against a transaction-level reference model.
module tb_aurora_hls_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int MB = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tready;
    logic [N-1:0]    s_axis_tlast;
    logic [N*KW-1:0] s_axis_tkeep;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [KW-1:0]   m_axis_tkeep;
    logic            fifo_tx_prog_full;
    logic [N-1:0]    grant;
    logic [31:0]     tx_beats;

    always #5 ap_clk = ~ap_clk;

    aurora_hls_tx_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
`ifdef AURORA_TX_ARB_PACKET_EN
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tkeep      (s_axis_tkeep),
`endif
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
`ifdef AURORA_TX_ARB_PACKET_EN
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tkeep      (m_axis_tkeep),
`endif
        .fifo_tx_prog_full (fifo_tx_prog_full),
        .grant             (grant),
        .tx_beats          (tx_beats)
    );

    // Producers: each holds a queue of beats; src_on means its head is being offered.
    beat_t src_q[N][$];
    bit    src_on[N];
    int    gap_pct;
    int    rdy_pct;

    // Reference model: owner (-1 when no grant), pointer, beats in burst, total beats.
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    logic [31:0] m_tx;

    // Observations of the DUT.
    int          burst_len_q[$];
    int          grant_order_q[$];
    int          cur_len;
    int          obs_cnt[N];
    logic [N-1:0] prev_grant;

    int n_cmp;
    int n_err;

    function automatic int oh_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return (m_owner < 0);
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i] = src_on[i];
            if (src_q[i].size() != 0) begin
                s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
                s_axis_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_axis_tlast[i]          = src_q[i][0].last;
            end else begin
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tkeep[i*KW +: KW] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input int beats, input int frame_len);
        beat_t b;
        for (int k = 0; k < beats; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = KW'($urandom);
            b.last = (frame_len > 0) && ((k % frame_len) == frame_len - 1);
            src_q[i].push_back(b);
        end
        if (beats > 0) src_on[i] = 1'b1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            src_on[i]  = 1'b0;
            obs_cnt[i] = 0;
        end
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_tx    = '0;
        burst_len_q.delete();
        grant_order_q.delete();
        cur_len           = 0;
        prev_grant        = '0;
        gap_pct           = 0;
        rdy_pct           = 100;
        m_axis_tready     = 1'b1;
        fifo_tx_prog_full = 1'b0;
        drive_src();
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        clear_env();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        beat_t        eb;
        eg = '0;
        er = '0;
        ev = 1'b0;
        eb = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = m_axis_tready;
            ev          = src_on[m_owner];
            if (ev) eb = src_q[m_owner][0];
        end
        n_cmp++;
        if (grant !== eg) begin
            n_err++;
            $display("FAIL grant t=%0t got %b want %b", $time, grant, eg);
        end
        n_cmp++;
        if (m_axis_tvalid !== ev) begin
            n_err++;
            $display("FAIL m_tvalid t=%0t got %b want %b", $time, m_axis_tvalid, ev);
        end
        n_cmp++;
        if (s_axis_tready !== er) begin
            n_err++;
            $display("FAIL s_tready t=%0t got %b want %b", $time, s_axis_tready, er);
        end
        n_cmp++;
        if (tx_beats !== m_tx) begin
            n_err++;
            $display("FAIL tx_beats t=%0t got %0d want %0d", $time, tx_beats, m_tx);
        end
        if (ev) begin
            n_cmp++;
            if (m_axis_tdata !== eb.data) begin
                n_err++;
                $display("FAIL m_tdata t=%0t got %h want %h", $time, m_axis_tdata, eb.data);
            end
`ifdef AURORA_TX_ARB_PACKET_EN
            n_cmp++;
            if (m_axis_tkeep !== eb.keep || m_axis_tlast !== eb.last) begin
                n_err++;
                $display("FAIL keep_last t=%0t got %h/%b want %h/%b", $time,
                         m_axis_tkeep, m_axis_tlast, eb.keep, eb.last);
            end
`endif
        end
    endtask

    // Advance the model across one clock edge using the inputs offered this cycle.
    task automatic model_step();
        bit accd[N];
        bit acc;
        bit lst;
        bit endb;
        for (int i = 0; i < N; i++) accd[i] = 1'b0;
        if (m_owner < 0) begin
            if (!fifo_tx_prog_full) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && src_on[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_cnt   = 0;
                    end
                end
            end
        end else begin
            acc = src_on[m_owner] && m_axis_tready;
            lst = 1'b0;
            if (acc) begin
                lst            = src_q[m_owner][0].last;
                accd[m_owner]  = 1'b1;
                m_cnt++;
                m_tx++;
            end
`ifdef AURORA_TX_ARB_PACKET_EN
            endb = acc && lst;
`else
            endb = acc ? (m_cnt == MB) : !src_on[m_owner];
`endif
            if (endb) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (accd[i]) begin
                void'(src_q[i].pop_front());
                src_on[i] = 1'b0;
            end
            if (!src_on[i] && src_q[i].size() != 0 && int'($urandom_range(99)) >= gap_pct)
                src_on[i] = 1'b1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] g_now;
        logic         acc_now;
        drive_src();
        #1;
        check_outputs();
        g_now   = grant;
        acc_now = m_axis_tvalid & m_axis_tready;
        if (prev_grant != '0 && g_now == '0) begin
            burst_len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (prev_grant == '0 && g_now != '0) grant_order_q.push_back(oh_idx(g_now));
        if (g_now != '0 && acc_now) begin
            cur_len++;
            obs_cnt[oh_idx(g_now)]++;
        end
        prev_grant = g_now;
        @(posedge ap_clk);
        model_step();
        @(negedge ap_clk);
        m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int c;
        c = 0;
        while (!all_done() && c < budget) begin
            tick();
            c++;
        end
        tick();
        tick();
        n_cmp++;
        if (!all_done()) begin
            n_err++;
            $display("FAIL %s_drain got busy after %0d cycles want idle", tag, budget);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        clear_env();
        for (int i = 0; i < N; i++) load(i, 4, 4);
        drive_src();
        @(negedge ap_clk);
        @(negedge ap_clk);
        n_cmp++;
        if (grant !== '0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || tx_beats !== '0)
        begin
            n_err++;
            $display("FAIL reset_values got g=%b v=%b r=%b tx=%0d want all zero",
                     grant, m_axis_tvalid, s_axis_tready, tx_beats);
        end
        ap_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++;
        if (grant_order_q.size() < 1 || grant_order_q[0] != 0) begin
            n_err++;
            $display("FAIL reset_first_grant got %0d grants want requester 0 first",
                     grant_order_q.size());
        end
        run_until_idle(200, "reset");
    endtask

    task automatic test_single_stream();
        do_reset();
        load(0, 40, 0);
        run_until_idle(200, "single");
        n_cmp++;
        if (burst_len_q.size() != 3 || burst_len_q[0] != 16 || burst_len_q[1] != 16 ||
            burst_len_q[2] != 8) begin
            n_err++;
            $display("FAIL single_bursts got %0d bursts (first %0d) want 16,16,8",
                     burst_len_q.size(), (burst_len_q.size() > 0) ? burst_len_q[0] : -1);
        end
        n_cmp++;
        if (tx_beats !== 32'd40) begin
            n_err++;
            $display("FAIL single_tx_beats got %0d want 40", tx_beats);
        end
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        for (int i = 0; i < N; i++) load(i, 100, 0);
        c = 0;
        while (grant_order_q.size() < 5 && c < 200) begin
            tick();
            c++;
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (grant_order_q.size() <= k || grant_order_q[k] != (k % N)) begin
                n_err++;
                $display("FAIL rr_order[%0d] got %0d want %0d", k,
                         (grant_order_q.size() > k) ? grant_order_q[k] : -1, k % N);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (burst_len_q.size() <= k || burst_len_q[k] != MB) begin
                n_err++;
                $display("FAIL rr_len[%0d] got %0d want %0d", k,
                         (burst_len_q.size() > k) ? burst_len_q[k] : -1, MB);
            end
        end
        rdy_pct = 70;
        gap_pct = 10;
        run_until_idle(3000, "rr");
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_cnt[i] != 100) begin
                n_err++;
                $display("FAIL rr_scoreboard[%0d] got %0d beats want 100", i, obs_cnt[i]);
            end
        end
    endtask

    task automatic test_prog_full();
        int c;
        do_reset();
        fifo_tx_prog_full = 1'b1;
        load(2, 32, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (grant !== '0) begin
                n_err++;
                $display("FAIL pf_hold got %b want 0000", grant);
            end
        end
        fifo_tx_prog_full = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL pf_release got %b want 0100", grant);
        end
        for (int k = 0; k < 4; k++) tick();
        fifo_tx_prog_full = 1'b1;
        c = 0;
        while (burst_len_q.size() < 1 && c < 40) begin
            tick();
            c++;
        end
        n_cmp++;
        if (burst_len_q.size() < 1 || burst_len_q[0] != MB) begin
            n_err++;
            $display("FAIL pf_midburst got %0d beats want %0d",
                     (burst_len_q.size() > 0) ? burst_len_q[0] : -1, MB);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (grant !== '0) begin
            n_err++;
            $display("FAIL pf_after_burst got %b want 0000", grant);
        end
        fifo_tx_prog_full = 1'b0;
        run_until_idle(200, "pf");
    endtask

    task automatic test_tvalid_drop();
        int c;
        do_reset();
        load(1, 5, 0);
        load(2, 20, 0);
        c = 0;
        while (grant_order_q.size() < 2 && c < 60) begin
            tick();
            c++;
        end
        n_cmp++;
        if (grant_order_q.size() < 2 || grant_order_q[0] != 1 || grant_order_q[1] != 2 ||
            burst_len_q.size() < 1 || burst_len_q[0] != 5) begin
            n_err++;
            $display("FAIL drop_to_next got %0d grants, first len %0d want 1(5 beats) then 2",
                     grant_order_q.size(), (burst_len_q.size() > 0) ? burst_len_q[0] : -1);
        end
        run_until_idle(200, "drop_a");

        do_reset();
        load(1, 5, 0);
        c = 0;
        while (burst_len_q.size() < 1 && c < 60) begin
            tick();
            c++;
        end
        load(1, 5, 0);
        c = 0;
        while (grant_order_q.size() < 2 && c < 60) begin
            tick();
            c++;
        end
        n_cmp++;
        if (grant_order_q.size() < 2 || grant_order_q[1] != 1) begin
            n_err++;
            $display("FAIL drop_regrant got %0d grants want requester 1 re-granted",
                     grant_order_q.size());
        end
        run_until_idle(200, "drop_b");
    endtask

`ifdef AURORA_TX_ARB_PACKET_EN
    task automatic test_packet();
        do_reset();
        load(0, 3 * 37, 37);
        load(1, 3 * 37, 37);
        rdy_pct = 70;
        run_until_idle(2000, "pkt");
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (grant_order_q.size() <= k || grant_order_q[k] != (k % 2) ||
                burst_len_q.size() <= k || burst_len_q[k] != 37) begin
                n_err++;
                $display("FAIL pkt_frame[%0d] got %0d frames want src %0d len 37", k,
                         grant_order_q.size(), k % 2);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        int c;
        do_reset();
        load(0, 20, 16);
        load(1, 20, 16);
        rdy_pct = 60;
        c = 0;
        while (grant !== 4'b0010 && c < 300) begin
            tick();
            c++;
        end
        for (int k = 0; k < 3; k++) tick();
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant !== '0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || tx_beats !== '0)
        begin
            n_err++;
            $display("FAIL async_reset got g=%b v=%b r=%b tx=%0d want all zero",
                     grant, m_axis_tvalid, s_axis_tready, tx_beats);
        end
        clear_env();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < N; i++) load(i, 5, 5);
        c = 0;
        while (grant_order_q.size() < 1 && c < 20) begin
            tick();
            c++;
        end
        n_cmp++;
        if (grant_order_q.size() < 1 || grant_order_q[0] != 0) begin
            n_err++;
            $display("FAIL reset_restart got %0d want first grant to requester 0",
                     (grant_order_q.size() > 0) ? grant_order_q[0] : -1);
        end
        run_until_idle(300, "rst_mid");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tkeep  = '0;
        test_reset();
`ifdef AURORA_TX_ARB_PACKET_EN
        test_packet();
`else
        test_single_stream();
        test_round_robin();
        test_prog_full();
        test_tvalid_drop();
`endif
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
